score_timer: RTL and testbench
==============================

SCORE_TIMER -- requirements
Module: score_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency used to derive the 1 Hz tick.
REQ-002 The block SHALL have parameter GAME_SECONDS, default 60, match length in seconds; legal range 1..63.
REQ-003 The block SHALL have parameter WIN_SCORE, default 9, score that ends the match early; legal range 1..9.
REQ-004 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: start/restart request, level, rising-edge detected internally.
REQ-007 The block SHALL have ports goal1 and goal2, input, 1 bit each: player goal events, level, rising-edge detected internally.
REQ-008 The block SHALL have ports score1 and score2, output, 4 bits each: player scores, 0..9, consumed by the text overlay.
REQ-009 The block SHALL have port seconds, output, 6 bits: remaining match time, consumed by the text overlay.
REQ-010 The block SHALL have port state, output, 2 bits: game state encoding (see REQ-013).
REQ-011 The block SHALL have port winner, output, 2 bits: 00 none, 01 player 1, 10 player 2, 11 draw; valid in OVER.

Function
REQ-012 Each of start, goal1 and goal2 SHALL pass through a 2-flop synchroniser plus a previous-value flop; an event is a 0->1 transition, giving 3 cycles of latency from pin to event.
REQ-013 The FSM SHALL have states IDLE=0, PLAY=1, OVER=2 (3 unused, recovers to IDLE next cycle).
REQ-014 In IDLE, a start event SHALL move the FSM to PLAY, clear both scores, load seconds=GAME_SECONDS and clear the prescaler, all in the same cycle.
REQ-015 In PLAY, the prescaler SHALL count 0..CLK_HZ-1, and its wrap SHALL produce a one-cycle tick that decrements seconds by 1.
REQ-016 In PLAY, goal1 or goal2 events SHALL increment the matching score by 1, saturating at 9; simultaneous goal1 and goal2 events SHALL both count.
REQ-017 The FSM SHALL move PLAY->OVER when a tick takes seconds from 1 to 0, or when any score reaches WIN_SCORE.
REQ-018 A goal that coincides with the final tick SHALL be counted before winner is evaluated.
REQ-019 On entry to OVER, winner SHALL be latched: the higher score wins, and equal scores give 11.
REQ-020 In PLAY, start events SHALL be ignored; in OVER, a start event SHALL return to IDLE, clear scores and winner, and load seconds=GAME_SECONDS.
REQ-021 Goal events outside PLAY SHALL be ignored, and seconds SHALL stay frozen outside PLAY.
REQ-022 All outputs SHALL be registered; an event at the block boundary SHALL be visible on the outputs 4 cycles after the pin edge.

Reset
REQ-023 Asserting rst_n low SHALL asynchronously force state=IDLE, score1=0, score2=0, seconds=GAME_SECONDS, winner=00, and clear the prescaler and all synchroniser/edge flops.
REQ-024 Reset asserted mid-PLAY SHALL abandon the match with no partial update, and release SHALL require a fresh start edge to play.

Configuration
REQ-025 Macro SCORE_TIMER_PAUSE_EN, when defined, SHALL add input pause (1 bit, synchronised and edge-detected like start) and state PAUSED=3.
REQ-026 With the macro defined, a pause event in PLAY SHALL move to PAUSED, freezing the prescaler, seconds and scores; a pause event in PAUSED SHALL return to PLAY with the prescaler value preserved.
REQ-027 With the macro defined, a start event in PAUSED SHALL go to IDLE.
REQ-028 Without the macro, no pause port SHALL exist and encoding 3 SHALL be illegal (recovers to IDLE).

Structure
REQ-029 Package game_pkg SHALL hold the game_state_t enum (IDLE/PLAY/OVER/PAUSED), the winner codes, and the MAX_SCORE=9 and SECONDS_W=6 constants, shared with the display path.
REQ-030 The prescaler SHALL be sub-module tick_gen (params CLK_HZ; ports clk, rst_n, clr, en, tick), and the synchroniser/edge logic SHALL stay inline.

Verification (benches use CLK_HZ=10, GAME_SECONDS=3, WIN_SCORE=9)
REQ-031 The bench SHALL check: reset then start pulse -> state=1 and seconds=3 four cycles later; seconds reaches 2, 1, 0 at 10-cycle intervals; state=2 and winner=11 at 0.
REQ-032 The bench SHALL check: goal1 pulses x2 and goal2 pulse x1 in PLAY -> score1=2, score2=1; at timeout winner=01.
REQ-033 The bench SHALL check: goal1 and goal2 rising on the same cycle -> both scores +1; ten goal1 pulses -> score1 saturates at 9 and state=OVER at the 9th pulse.
REQ-034 The bench SHALL check: goal1 held high for 20 cycles -> score1 increments by exactly 1; goals in IDLE and OVER -> scores unchanged.
REQ-035 The bench SHALL check: rst_n low mid-PLAY with score1=3 and seconds=1 -> immediately score1=0, seconds=3, state=0, with no update on release.
REQ-036 With SCORE_TIMER_PAUSE_EN defined, the bench SHALL check: pause at 5 cycles into second 3 -> seconds holds 3 for 50 cycles; after unpause, the decrement to 2 occurs 5 cycles later.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, winner codes and score/time widths,
// used by score_timer and the text-overlay display path.
package game_pkg;

    localparam int MAX_SCORE = 9;
    localparam int SECONDS_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        OVER   = 2'd2,
        PAUSED = 2'd3
    } game_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Score increment that sticks at MAX_SCORE.
    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic inc);
        logic [3:0] r;
        if (inc && (s < 4'(MAX_SCORE))) begin
            r = s + 4'd1;
        end else begin
            r = s;
        end
        return r;
    endfunction

    function automatic logic [1:0] winner_of(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] w;
        if (a > b) begin
            w = WIN_P1;
        end else if (b > a) begin
            w = WIN_P2;
        end else begin
            w = WIN_DRAW;
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler that divides the system clock down to a one-cycle 1 Hz tick.
// Counting holds while en is low, so a paused match keeps its sub-second phase.
module tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;

    // Prescaler counter: cleared on match start, wraps at CLK_HZ-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign tick = en & ~clr & (r_cnt == LAST);

endmodule

// File: rtl/score_timer.sv
// Two-player match controller: scores, countdown timer and winner for the overlay.
// Optional pause input and PAUSED state are enabled by defining SCORE_TIMER_PAUSE_EN.
module score_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int GAME_SECONDS = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 goal1,
    input  logic                 goal2,
`ifdef SCORE_TIMER_PAUSE_EN
    input  logic                 pause,
`endif
    output logic [3:0]           score1,
    output logic [3:0]           score2,
    output logic [SECONDS_W-1:0] seconds,
    output logic [1:0]           state,
    output logic [1:0]           winner
);

    localparam int EV_START = 0;
    localparam int EV_GOAL1 = 1;
    localparam int EV_GOAL2 = 2;
`ifdef SCORE_TIMER_PAUSE_EN
    localparam int EV_PAUSE = 3;
    localparam int NIN      = 4;
`else
    localparam int NIN      = 3;
`endif

    localparam logic [SECONDS_W-1:0] SEC_INIT = SECONDS_W'(GAME_SECONDS);
    localparam logic [3:0]           WIN_S    = 4'(WIN_SCORE);

    logic [NIN-1:0] w_pins;
    logic [NIN-1:0] r_sync1;
    logic [NIN-1:0] r_sync2;
    logic [NIN-1:0] r_prev;
    logic [NIN-1:0] r_evt;

`ifdef SCORE_TIMER_PAUSE_EN
    assign w_pins = {pause, goal2, goal1, start};
`else
    assign w_pins = {goal2, goal1, start};
`endif

    // Pin synchronisers and registered rising-edge events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_evt   <= '0;
        end else begin
            r_sync1 <= w_pins;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_evt   <= r_sync2 & ~r_prev;
        end
    end

    logic w_start_ev;
    logic w_goal1_ev;
    logic w_goal2_ev;
    assign w_start_ev = r_evt[EV_START];
    assign w_goal1_ev = r_evt[EV_GOAL1];
    assign w_goal2_ev = r_evt[EV_GOAL2];
`ifdef SCORE_TIMER_PAUSE_EN
    logic w_pause_ev;
    assign w_pause_ev = r_evt[EV_PAUSE];
`endif

    game_state_t          r_state;
    logic [3:0]           r_score1;
    logic [3:0]           r_score2;
    logic [SECONDS_W-1:0] r_seconds;
    logic [1:0]           r_winner;

    game_state_t          w_state_nxt;
    logic [3:0]           w_score1_nxt;
    logic [3:0]           w_score2_nxt;
    logic [SECONDS_W-1:0] w_seconds_nxt;
    logic [1:0]           w_winner_nxt;
    logic                 w_clr;
    logic                 w_en;
    logic                 w_tick;
    logic [3:0]           w_s1_inc;
    logic [3:0]           w_s2_inc;
    logic                 w_timeout;

    assign w_en = (r_state == PLAY);

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .en    (w_en),
        .tick  (w_tick)
    );

    assign w_s1_inc  = sat_inc(r_score1, w_goal1_ev);
    assign w_s2_inc  = sat_inc(r_score2, w_goal2_ev);
    assign w_timeout = w_tick && (r_seconds == SECONDS_W'(1));

    // Next-state logic; goals are folded into the scores before winner is judged.
    always_comb begin
        w_state_nxt   = r_state;
        w_score1_nxt  = r_score1;
        w_score2_nxt  = r_score2;
        w_seconds_nxt = r_seconds;
        w_winner_nxt  = r_winner;
        w_clr         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ev) begin
                    w_state_nxt   = PLAY;
                    w_score1_nxt  = 4'd0;
                    w_score2_nxt  = 4'd0;
                    w_seconds_nxt = SEC_INIT;
                    w_winner_nxt  = WIN_NONE;
                    w_clr         = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PLAY: begin
                w_score1_nxt = w_s1_inc;
                w_score2_nxt = w_s2_inc;
                if (w_tick) begin
                    w_seconds_nxt = r_seconds - SECONDS_W'(1);
                end else begin
                    w_seconds_nxt = r_seconds;
                end
                if (w_timeout || (w_s1_inc >= WIN_S) || (w_s2_inc >= WIN_S)) begin
                    w_state_nxt  = OVER;
                    w_winner_nxt = winner_of(w_s1_inc, w_s2_inc);
`ifdef SCORE_TIMER_PAUSE_EN
                end else if (w_pause_ev) begin
                    w_state_nxt = PAUSED;
`endif
                end else begin
                    w_state_nxt = PLAY;
                end
            end
            OVER: begin
                if (w_start_ev) begin
                    w_state_nxt   = IDLE;
                    w_score1_nxt  = 4'd0;
                    w_score2_nxt  = 4'd0;
                    w_seconds_nxt = SEC_INIT;
                    w_winner_nxt  = WIN_NONE;
                end else begin
                    w_state_nxt = OVER;
                end
            end
`ifdef SCORE_TIMER_PAUSE_EN
            PAUSED: begin
                if (w_start_ev) begin
                    w_state_nxt   = IDLE;
                    w_score1_nxt  = 4'd0;
                    w_score2_nxt  = 4'd0;
                    w_seconds_nxt = SEC_INIT;
                    w_winner_nxt  = WIN_NONE;
                end else if (w_pause_ev) begin
                    w_state_nxt = PLAY;
                end else begin
                    w_state_nxt = PAUSED;
                end
            end
`endif
            default: begin
                w_state_nxt   = IDLE;
                w_score1_nxt  = 4'd0;
                w_score2_nxt  = 4'd0;
                w_seconds_nxt = SEC_INIT;
                w_winner_nxt  = WIN_NONE;
            end
        endcase
    end

    // Game state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_score1  <= 4'd0;
            r_score2  <= 4'd0;
            r_seconds <= SEC_INIT;
            r_winner  <= WIN_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_score1  <= w_score1_nxt;
            r_score2  <= w_score2_nxt;
            r_seconds <= w_seconds_nxt;
            r_winner  <= w_winner_nxt;
        end
    end

    assign state   = r_state;
    assign score1  = r_score1;
    assign score2  = r_score2;
    assign seconds = r_seconds;
    assign winner  = r_winner;

endmodule

// File: tb/tb_score_timer.sv
// Bench for score_timer: directed scenario tasks plus a randomized run against
// a rule-level game model. Define SCORE_TIMER_PAUSE_EN to exercise pause.
module tb_score_timer;

    localparam int CLK_HZ       = 10;
    localparam int GAME_SECONDS = 3;
    localparam int WIN_SCORE    = 9;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       goal1 = 1'b0;
    logic       goal2 = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [5:0] seconds;
    logic [1:0] state;
    logic [1:0] winner;

    int pass_cnt  = 0;
    int total_cnt = 0;

    score_timer #(
        .CLK_HZ       (CLK_HZ),
        .GAME_SECONDS (GAME_SECONDS),
        .WIN_SCORE    (WIN_SCORE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .goal1   (goal1),
        .goal2   (goal2),
`ifdef SCORE_TIMER_PAUSE_EN
        .pause   (pause),
`endif
        .score1  (score1),
        .score2  (score2),
        .seconds (seconds),
        .state   (state),
        .winner  (winner)
    );

    always #5 clk = ~clk;

    // Rule-level model: an input edge takes effect on the 4th rising clock
    // after the pin changes; the game rules are applied in whole-cycle steps.
    typedef struct {
        int st;
        int s1;
        int s2;
        int sec;
        int elapsed;
        int win;
    } model_t;

    model_t m;
    logic [3:0] h_start, h_g1, h_g2, h_p;

    function automatic model_t model_step(model_t c, bit ev_st, bit ev_g1, bit ev_g2, bit ev_p);
        model_t n;
        bit tick;
        n = c;
        case (c.st)
            0: if (ev_st) begin
                n.st = 1; n.s1 = 0; n.s2 = 0; n.sec = GAME_SECONDS; n.elapsed = 0; n.win = 0;
            end
            1: begin
                tick = (c.elapsed == CLK_HZ - 1);
                n.elapsed = tick ? 0 : c.elapsed + 1;
                if (ev_g1 && c.s1 < 9) n.s1 = c.s1 + 1;
                if (ev_g2 && c.s2 < 9) n.s2 = c.s2 + 1;
                if (tick) n.sec = c.sec - 1;
                if ((tick && c.sec == 1) || n.s1 >= WIN_SCORE || n.s2 >= WIN_SCORE) begin
                    n.st  = 2;
                    n.win = (n.s1 > n.s2) ? 1 : (n.s2 > n.s1) ? 2 : 3;
                end else if (ev_p) begin
                    n.st = 3;
                end
            end
            2: if (ev_st) begin
                n.st = 0; n.s1 = 0; n.s2 = 0; n.win = 0; n.sec = GAME_SECONDS;
            end
            default: if (ev_st) begin
                n.st = 0; n.s1 = 0; n.s2 = 0; n.win = 0; n.sec = GAME_SECONDS;
            end else if (ev_p) begin
                n.st = 1;
            end
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '{0, 0, 0, GAME_SECONDS, 0, 0};
            h_start <= 4'd0;
            h_g1    <= 4'd0;
            h_g2    <= 4'd0;
            h_p     <= 4'd0;
        end else begin
            h_start <= {h_start[2:0], start};
            h_g1    <= {h_g1[2:0], goal1};
            h_g2    <= {h_g2[2:0], goal2};
            h_p     <= {h_p[2:0], pause};
            m       <= model_step(m, h_start[2] & ~h_start[3], h_g1[2] & ~h_g1[3],
                                  h_g2[2] & ~h_g2[3], h_p[2] & ~h_p[3]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start pulse, returning once the resulting state change is visible.
    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0; step(3);
    endtask

    task automatic start_game();
        if (state != 2'd0) pulse_start();
        pulse_start();
    endtask

    task automatic pulse_goal(input bit g1, input bit g2);
        goal1 = g1; goal2 = g2; step(1);
        goal1 = 1'b0; goal2 = 1'b0; step(1);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        step(3);
        total_cnt++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else pass_cnt++;
        total_cnt++; if (seconds !== 6'd3) $display("FAIL reset_seconds: got %0d expected 3", seconds); else pass_cnt++;
        total_cnt++; if ({score1, score2} !== 8'h00) $display("FAIL reset_scores: got %0d/%0d expected 0/0", score1, score2); else pass_cnt++;
        total_cnt++; if (winner !== 2'b00) $display("FAIL reset_winner: got %0d expected 0", winner); else pass_cnt++;
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_countdown();
        pulse_start();
        total_cnt++; if (state !== 2'd1) $display("FAIL cd_play: got %0d expected 1", state); else pass_cnt++;
        total_cnt++; if (seconds !== 6'd3) $display("FAIL cd_sec3: got %0d expected 3", seconds); else pass_cnt++;
        step(9);
        total_cnt++; if (seconds !== 6'd3) $display("FAIL cd_sec3_hold: got %0d expected 3", seconds); else pass_cnt++;
        step(1);
        total_cnt++; if (seconds !== 6'd2) $display("FAIL cd_sec2: got %0d expected 2", seconds); else pass_cnt++;
        step(10);
        total_cnt++; if (seconds !== 6'd1) $display("FAIL cd_sec1: got %0d expected 1", seconds); else pass_cnt++;
        step(10);
        total_cnt++; if (seconds !== 6'd0) $display("FAIL cd_sec0: got %0d expected 0", seconds); else pass_cnt++;
        total_cnt++; if (state !== 2'd2) $display("FAIL cd_over: got %0d expected 2", state); else pass_cnt++;
        total_cnt++; if (winner !== 2'b11) $display("FAIL cd_draw: got %0d expected 3", winner); else pass_cnt++;
        step(5);
        total_cnt++; if (seconds !== 6'd0) $display("FAIL cd_frozen: got %0d expected 0", seconds); else pass_cnt++;
    endtask

    task automatic test_goals();
        start_game();
        pulse_goal(1'b1, 1'b0);
        pulse_goal(1'b1, 1'b0);
        pulse_goal(1'b0, 1'b1);
        step(4);
        total_cnt++; if (score1 !== 4'd2) $display("FAIL goals_s1: got %0d expected 2", score1); else pass_cnt++;
        total_cnt++; if (score2 !== 4'd1) $display("FAIL goals_s2: got %0d expected 1", score2); else pass_cnt++;
        step(19);
        total_cnt++; if (state !== 2'd1) $display("FAIL goals_still_play: got %0d expected 1", state); else pass_cnt++;
        step(1);
        total_cnt++; if (state !== 2'd2) $display("FAIL goals_over: got %0d expected 2", state); else pass_cnt++;
        total_cnt++; if (winner !== 2'b01) $display("FAIL goals_winner: got %0d expected 1", winner); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        start_game();
        pulse_goal(1'b1, 1'b1);
        step(3);
        total_cnt++; if ({score1, score2} !== {4'd1, 4'd1}) $display("FAIL simul_scores: got %0d/%0d expected 1/1", score1, score2); else pass_cnt++;
        step(25);
        total_cnt++; if (winner !== 2'b11) $display("FAIL simul_draw: got %0d expected 3", winner); else pass_cnt++;
    endtask

    task automatic test_saturation();
        start_game();
        for (int k = 0; k < 9; k++) pulse_goal(1'b1, 1'b0);
        step(2);
        total_cnt++; if (score1 !== 4'd9) $display("FAIL sat_s1_9: got %0d expected 9", score1); else pass_cnt++;
        total_cnt++; if (state !== 2'd2) $display("FAIL sat_over: got %0d expected 2", state); else pass_cnt++;
        total_cnt++; if (winner !== 2'b01) $display("FAIL sat_winner: got %0d expected 1", winner); else pass_cnt++;
        pulse_goal(1'b1, 1'b0);
        pulse_goal(1'b0, 1'b1);
        step(4);
        total_cnt++; if ({score1, score2} !== {4'd9, 4'd0}) $display("FAIL sat_over_goals: got %0d/%0d expected 9/0", score1, score2); else pass_cnt++;
    endtask

    task automatic test_hold();
        start_game();
        goal1 = 1'b1; step(20); goal1 = 1'b0; step(4);
        total_cnt++; if (score1 !== 4'd1) $display("FAIL hold_once: got %0d expected 1", score1); else pass_cnt++;
        step(6);
        total_cnt++; if (state !== 2'd2) $display("FAIL hold_over: got %0d expected 2", state); else pass_cnt++;
        pulse_start();
        pulse_goal(1'b1, 1'b1);
        step(4);
        total_cnt++; if ({state, score1, score2} !== 10'd0) $display("FAIL idle_goals: got st%0d %0d/%0d expected st0 0/0", state, score1, score2); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        start_game();
        for (int k = 0; k < 3; k++) pulse_goal(1'b1, 1'b0);
        step(19);
        total_cnt++; if ({score1, seconds} !== {4'd3, 6'd1}) $display("FAIL mid_pre: got %0d/%0d expected 3/1", score1, seconds); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if ({state, score1, seconds} !== {2'd0, 4'd0, 6'd3}) $display("FAIL mid_async: got st%0d s1 %0d sec %0d expected st0 s1 0 sec 3", state, score1, seconds); else pass_cnt++;
        step(2);
        rst_n = 1'b1;
        step(10);
        total_cnt++; if ({state, score1, seconds} !== {2'd0, 4'd0, 6'd3}) $display("FAIL mid_release: got st%0d s1 %0d sec %0d expected st0 s1 0 sec 3", state, score1, seconds); else pass_cnt++;
        start_game();
        total_cnt++; if (state !== 2'd1) $display("FAIL mid_restart: got %0d expected 1", state); else pass_cnt++;
        step(30);
    endtask

`ifdef SCORE_TIMER_PAUSE_EN
    task automatic test_pause();
        start_game();
        step(1);
        pause = 1'b1; step(1); pause = 1'b0; step(3);
        total_cnt++; if ({state, seconds} !== {2'd3, 6'd3}) $display("FAIL pause_enter: got st%0d sec %0d expected st3 sec 3", state, seconds); else pass_cnt++;
        step(50);
        total_cnt++; if ({state, seconds} !== {2'd3, 6'd3}) $display("FAIL pause_hold: got st%0d sec %0d expected st3 sec 3", state, seconds); else pass_cnt++;
        pause = 1'b1; step(1); pause = 1'b0; step(3);
        total_cnt++; if (state !== 2'd1) $display("FAIL pause_resume: got %0d expected 1", state); else pass_cnt++;
        step(4);
        total_cnt++; if (seconds !== 6'd3) $display("FAIL pause_phase_hold: got %0d expected 3", seconds); else pass_cnt++;
        step(1);
        total_cnt++; if (seconds !== 6'd2) $display("FAIL pause_phase_dec: got %0d expected 2", seconds); else pass_cnt++;
        step(25);
    endtask
`endif

    task automatic test_random();
        logic [17:0] exp_v;
        logic [17:0] got_v;
        for (int i = 0; i < 1200; i++) begin
            goal1 = ($urandom_range(0, 3) == 0);
            goal2 = ($urandom_range(0, 3) == 0);
            start = ($urandom_range(0, 39) == 0);
`ifdef SCORE_TIMER_PAUSE_EN
            pause = ($urandom_range(0, 29) == 0);
`endif
            if (i == 600) rst_n = 1'b0;
            if (i == 603) rst_n = 1'b1;
            step(1);
            exp_v = {2'(m.st), 4'(m.s1), 4'(m.s2), 6'(m.sec), 2'(m.win)};
            got_v = {state, score1, score2, seconds, winner};
            total_cnt++;
            if (got_v !== exp_v)
                $display("FAIL random_cycle%0d: got st%0d %0d/%0d sec%0d win%0d expected st%0d %0d/%0d sec%0d win%0d",
                         i, state, score1, score2, seconds, winner, m.st, m.s1, m.s2, m.sec, m.win);
            else pass_cnt++;
        end
        goal1 = 1'b0; goal2 = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_goals();
        test_simultaneous();
        test_saturation();
        test_hold();
        test_reset_mid();
`ifdef SCORE_TIMER_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
